uart_tx_datapath: RTL and testbench
===================================

// Module: uart_tx_datapath
// PURPOSE
//  Downstream datapath of the UART TX control FSM: captures the parallel byte, serialises it LSB-first,
//  computes parity, and drives the registered serial line from the FSM's sel_line. Returns the bit counter
//  and SRL_done to the FSM. Sends one bit per clk; any baud enable lives outside this block.
// PARAMETERS
//  WIDTH          8  data bits per frame (1..15; counter is 4 bits)
//  SEL_START      1  sel_line code: drive start bit (0)
//  SEL_STP        2  sel_line code: drive stop/idle (1)
//  SEL_SRL        3  sel_line code: drive next serializer bit
//  SEL_PAR        4  sel_line code: drive parity bit
// PORTS
//  clk              in   1      clock
//  rst              in   1      asynchronous active-low reset
//  P_DATA           in   WIDTH  parallel data to transmit
//  DATA_VALID       in   1      P_DATA valid; captured only while idle
//  PAR_TYP          in   1      0 = even parity, 1 = odd parity
//  serializer_load  in   1      explicit load strobe from FSM (OR-ed with the idle capture)
//  sel_line         in   3      output-mux select from FSM (codes above)
//  TX_OUT           out  1      serial line, registered
//  counter          out  4      bit counter to FSM
//  SRL_done         out  1      counter == WIDTH
//  busy             out  1      frame in progress, registered
// BEHAVIOUR
//  - Reset (async, rst=0): TX_OUT=1, busy=0, counter=0, SRL_done=0, shift reg=0, parity reg=0.
//    Applies immediately mid-frame; frame is abandoned, line returns high.
//  - Capture: load = serializer_load | (DATA_VALID & sel_line==SEL_STP). On load:
//    shreg<=P_DATA; par<=^P_DATA ^ PAR_TYP. P_DATA/PAR_TYP changes after capture are ignored.
//    DATA_VALID while sel_line!=SEL_STP (and no serializer_load) is ignored and not queued.
//  - Output mux, registered (1-cycle latency from sel_line to TX_OUT):
//    SEL_START->0; SEL_SRL->shreg[0], then shreg>>=1 (zero fill); SEL_PAR->par; SEL_STP->1.
//    Codes 0,5,6,7 -> 1 (idle); shreg/counter hold.
//  - Counter: sel_line==SEL_START -> counter<=1; sel_line==SEL_SRL -> counter<=counter+1, saturating
//    at WIDTH; sel_line==SEL_STP -> counter<=0; other codes hold.
//    Result: exactly WIDTH shift cycles per frame when FSM leaves SRL on observing counter==WIDTH.
//  - SRL_done: combinational (counter==WIDTH).
//  - busy: registered; <=1 when sel_line is SEL_START/SRL/PAR; <=0 when sel_line==SEL_STP.
//  - Simultaneous load and SEL_SRL on the same cycle: load wins for shreg; mux still emits old shreg[0].
//  - Back-to-back frames: the capture in the SEL_STP cycle ends the stop bit; no extra idle is inserted.
// STRUCTURE
//  - Shared package/include uart_tx_defs: SEL_* codes, default WIDTH, counter width (4). Used by this
//    block and the TX FSM.
//  - One sub-module: uart_parity_calc (WIDTH data, PAR_TYP, load -> registered par bit).
//  - Serializer, counter, mux, and busy stay inline.
// TESTING
//  1. rst low mid-frame (after 3 data bits) -> next edge-free sample: TX_OUT=1, busy=0, counter=0.
//  2. P_DATA=8'hA5, no parity, FSM sel sequence START, SRL x8, STP ->
//     TX_OUT = 0,1,0,1,0,0,1,0,1,1. Counter observed 1,2..8 (saturating); SRL_done high on last SRL.
//  3. P_DATA=8'hA5 with PAR_TYP=0 -> parity bit 0; PAR_TYP=1 -> parity bit 1.
//     P_DATA=8'h07, PAR_TYP=0 -> parity bit 1.
//  4. Change P_DATA to 8'hFF mid-frame and pulse DATA_VALID -> frame bits unchanged (A5 pattern),
//     no second frame queued.
//  5. Back-to-back frames 8'h3C then 8'hC3, DATA_VALID held -> single stop bit between frames, both
//     correct LSB-first.
//  6. sel_line=0/5/7 for 3 cycles mid-SRL -> TX_OUT=1, counter and shreg hold;
//     resuming SEL_SRL continues with the next unsent bit.

Source files
------------

// File: rtl/uart_tx_defs.sv
// Shared definitions for the UART TX FSM and its datapath: output-mux select codes,
// default frame width and bit-counter width.
package uart_tx_defs;

  localparam int DEFAULT_WIDTH = 8;
  localparam int CNT_W         = 4;
  localparam int MAX_WIDTH     = 15;

  typedef enum logic [2:0] {
    SEL_IDLE  = 3'd0,
    SEL_START = 3'd1,
    SEL_STP   = 3'd2,
    SEL_SRL   = 3'd3,
    SEL_PAR   = 3'd4
  } sel_code_e;

  // Zero padding up to MAX_WIDTH leaves the XOR reduction unchanged.
  function automatic logic parity_bit(input logic [MAX_WIDTH-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// Registered parity bit for the UART TX frame; updated only when a new byte is captured
// so later changes on the data or parity-type inputs cannot disturb a frame in flight.
module uart_parity_calc
  import uart_tx_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic             par_typ,
  input  logic             load,
  output logic             par
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par <= 1'b0;
    end else if (load) begin
      par <= parity_bit(MAX_WIDTH'(data), par_typ);
    end
  end

endmodule

// File: rtl/uart_tx_datapath.sv
// UART TX datapath: captures the byte, shifts it out LSB-first and drives the registered
// serial line from the FSM's select code, one bit per clk.
module uart_tx_datapath
  import uart_tx_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             DATA_VALID,
  input  logic             PAR_TYP,
  input  logic             serializer_load,
  input  logic [2:0]       sel_line,
  output logic             TX_OUT,
  output logic [CNT_W-1:0] counter,
  output logic             SRL_done,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  sel_code_e        sel;
  logic             load;
  logic             par;
  logic             tx_next;
  logic [WIDTH-1:0] shreg;

  assign sel  = sel_code_e'(sel_line);
  // Idle capture is only honoured while the line is in stop/idle; nothing is queued otherwise.
  assign load = serializer_load | (DATA_VALID & (sel == SEL_STP));

  uart_parity_calc #(
    .WIDTH (WIDTH)
  ) u_parity (
    .clk     (clk),
    .rst     (rst),
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .load    (load),
    .par     (par)
  );

  // A load in the same cycle as a shift replaces the register; the mux still sends the old bit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= P_DATA;
    end else if (sel == SEL_SRL) begin
      shreg <= shreg >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter <= '0;
    end else begin
      case (sel)
        SEL_START: counter <= CNT_W'(1);
        SEL_SRL:   if (counter != CNT_MAX) counter <= counter + CNT_W'(1);
        SEL_STP:   counter <= '0;
        default:   counter <= counter;
      endcase
    end
  end

  assign SRL_done = (counter == CNT_MAX);

  always_comb begin
    tx_next = 1'b1;
    case (sel)
      SEL_START: tx_next = 1'b0;
      SEL_SRL:   tx_next = shreg[0];
      SEL_PAR:   tx_next = par;
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      TX_OUT <= 1'b1;
    end else begin
      TX_OUT <= tx_next;
    end
  end

  // Unused select codes leave busy where it was, matching the hold behaviour of the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
    end else begin
      case (sel)
        SEL_START, SEL_SRL, SEL_PAR: busy <= 1'b1;
        SEL_STP:                     busy <= 1'b0;
        default:                     busy <= busy;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_datapath.sv
// Directed self-checking bench for uart_tx_datapath: frame bits, counter, parity,
// capture rules, back-to-back frames, hold codes and asynchronous reset.
module tb_uart_tx_datapath;
  import uart_tx_defs::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_typ;
  logic       serializer_load;
  logic [2:0] sel_line;
  logic       tx_out;
  logic [3:0] counter;
  logic       srl_done;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  uart_tx_datapath #(
    .WIDTH (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .P_DATA          (p_data),
    .DATA_VALID      (data_valid),
    .PAR_TYP         (par_typ),
    .serializer_load (serializer_load),
    .sel_line        (sel_line),
    .TX_OUT          (tx_out),
    .counter         (counter),
    .SRL_done        (srl_done),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a select code for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic apply_stimulus(input logic [2:0] sel);
    sel_line = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [7:0] data, input logic ptyp);
    p_data     = data;
    par_typ    = ptyp;
    data_valid = 1'b1;
    apply_stimulus(SEL_STP);
    data_valid = 1'b0;
  endtask

  task automatic start_bit(input string tag);
    apply_stimulus(SEL_START);
    exp_cnt = 1;
    check_output({tag, " start"}, 4'(tx_out), 4'd0);
    check_output({tag, " start cnt"}, counter, 4'd1);
    check_output({tag, " start busy"}, 4'(busy), 4'd1);
  endtask

  task automatic srl_bits(input logic [7:0] data, input int first, input int last, input string tag);
    for (int k = first; k <= last; k++) begin
      apply_stimulus(SEL_SRL);
      if (exp_cnt != 8) exp_cnt++;
      check_output($sformatf("%s bit%0d", tag, k), 4'(tx_out), 4'(data[k]));
      check_output($sformatf("%s cnt%0d", tag, k), counter, 4'(exp_cnt));
    end
  endtask

  task automatic stop_bit(input string tag);
    apply_stimulus(SEL_STP);
    check_output({tag, " stop"}, 4'(tx_out), 4'd1);
    check_output({tag, " stop cnt"}, counter, 4'd0);
    check_output({tag, " stop busy"}, 4'(busy), 4'd0);
  endtask

  task automatic parity_frame(input logic [7:0] data, input logic ptyp, input logic exp_par, input string tag);
    capture(data, ptyp);
    par_typ = ~ptyp;
    start_bit(tag);
    srl_bits(data, 0, 7, tag);
    apply_stimulus(SEL_PAR);
    check_output({tag, " parity"}, 4'(tx_out), 4'(exp_par));
    stop_bit(tag);
  endtask

  initial begin
    rst             = 1'b0;
    p_data          = 8'h00;
    data_valid      = 1'b0;
    par_typ         = 1'b0;
    serializer_load = 1'b0;
    sel_line        = SEL_STP;
    #12;
    check_output("reset tx", 4'(tx_out), 4'd1);
    check_output("reset busy", 4'(busy), 4'd0);
    check_output("reset cnt", counter, 4'd0);
    check_output("reset done", 4'(srl_done), 4'd0);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(SEL_STP);

    $display("[TB] basic frame 0xA5");
    capture(8'hA5, 1'b0);
    check_output("a5 idle", 4'(tx_out), 4'd1);
    start_bit("a5");
    srl_bits(8'hA5, 0, 6, "a5");
    check_output("a5 done before last", 4'(srl_done), 4'd1);
    srl_bits(8'hA5, 7, 7, "a5");
    check_output("a5 done after last", 4'(srl_done), 4'd1);
    stop_bit("a5");
    check_output("a5 done cleared", 4'(srl_done), 4'd0);

    $display("[TB] parity frames");
    parity_frame(8'hA5, 1'b0, 1'b0, "par a5 even");
    parity_frame(8'hA5, 1'b1, 1'b1, "par a5 odd");
    parity_frame(8'h07, 1'b0, 1'b1, "par 07 even");

    $display("[TB] mid-frame data change ignored");
    capture(8'hA5, 1'b0);
    start_bit("chg");
    srl_bits(8'hA5, 0, 1, "chg");
    p_data     = 8'hFF;
    data_valid = 1'b1;
    srl_bits(8'hA5, 2, 2, "chg");
    data_valid = 1'b0;
    srl_bits(8'hA5, 3, 7, "chg");
    stop_bit("chg");
    apply_stimulus(SEL_STP);
    check_output("chg idle tx", 4'(tx_out), 4'd1);
    check_output("chg idle busy", 4'(busy), 4'd0);
    start_bit("chg empty");
    srl_bits(8'h00, 0, 7, "chg empty");
    stop_bit("chg empty");

    $display("[TB] back-to-back frames");
    p_data     = 8'h3C;
    data_valid = 1'b1;
    apply_stimulus(SEL_STP);
    start_bit("b2b 3c");
    srl_bits(8'h3C, 0, 7, "b2b 3c");
    p_data = 8'hC3;
    stop_bit("b2b 3c");
    start_bit("b2b c3");
    srl_bits(8'hC3, 0, 7, "b2b c3");
    data_valid = 1'b0;
    stop_bit("b2b c3");

    $display("[TB] hold codes mid-frame");
    capture(8'hA5, 1'b0);
    start_bit("hold");
    srl_bits(8'hA5, 0, 2, "hold");
    apply_stimulus(3'd0);
    check_output("hold code0 tx", 4'(tx_out), 4'd1);
    check_output("hold code0 cnt", counter, 4'd4);
    check_output("hold code0 busy", 4'(busy), 4'd1);
    apply_stimulus(3'd5);
    check_output("hold code5 tx", 4'(tx_out), 4'd1);
    check_output("hold code5 cnt", counter, 4'd4);
    apply_stimulus(3'd7);
    check_output("hold code7 tx", 4'(tx_out), 4'd1);
    check_output("hold code7 cnt", counter, 4'd4);
    srl_bits(8'hA5, 3, 7, "hold");
    stop_bit("hold");

    $display("[TB] load during shift");
    capture(8'hA5, 1'b0);
    start_bit("ldsh");
    srl_bits(8'hA5, 0, 0, "ldsh");
    p_data          = 8'h0E;
    serializer_load = 1'b1;
    apply_stimulus(SEL_SRL);
    serializer_load = 1'b0;
    check_output("ldsh old bit", 4'(tx_out), 4'd0);
    apply_stimulus(SEL_SRL);
    check_output("ldsh new bit0", 4'(tx_out), 4'd0);
    apply_stimulus(SEL_SRL);
    check_output("ldsh new bit1", 4'(tx_out), 4'd1);
    stop_bit("ldsh");

    $display("[TB] asynchronous reset mid-frame");
    capture(8'hA5, 1'b0);
    start_bit("rst");
    srl_bits(8'hA5, 0, 2, "rst");
    sel_line = SEL_SRL;
    #2;
    rst = 1'b0;
    #1;
    check_output("rst mid tx", 4'(tx_out), 4'd1);
    check_output("rst mid busy", 4'(busy), 4'd0);
    check_output("rst mid cnt", counter, 4'd0);
    check_output("rst mid done", 4'(srl_done), 4'd0);
    sel_line = SEL_STP;
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(SEL_STP);
    check_output("rst after tx", 4'(tx_out), 4'd1);
    check_output("rst after busy", 4'(busy), 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
